// File: rtl/pp_uart_regif_pkg.sv
// Shared definitions for the UART0 register interface.
// Register map, bit positions, reset constants, FSM encoding.
// No logic; no latency or backpressure of its own.
package pp_uart_regif_pkg;

    localparam logic [3:0] ADDR_TXDATA = 4'h0;
    localparam logic [3:0] ADDR_RXDATA = 4'h1;
    localparam logic [3:0] ADDR_CTRL   = 4'h2;
    localparam logic [3:0] ADDR_BAUD   = 4'h3;
    localparam logic [3:0] ADDR_STATUS = 4'h4;
    localparam logic [3:0] ADDR_TXLVL  = 4'h5;
    localparam logic [3:0] ADDR_RXLVL  = 4'h6;
    localparam logic [3:0] ADDR_IRQ_EN = 4'h7;
    localparam logic [3:0] ADDR_RX_THR = 4'h8;

    localparam int CTRL_DATA_LSB  = 0;
    localparam int CTRL_STOP_BIT  = 2;
    localparam int CTRL_CHECK_LSB = 3;
    localparam int CTRL_SRST_BIT  = 15;

    localparam int STS_TX_WRFULL  = 0;
    localparam int STS_TX_RDEMPTY = 1;
    localparam int STS_RX_WRFULL  = 2;
    localparam int STS_RX_RDEMPTY = 3;
    localparam int STS_TX_ERROR   = 4;
    localparam int STS_RX_ERROR   = 5;
    localparam int STS_IRQ        = 6;

    localparam int IRQ_RX_LVL   = 0;
    localparam int IRQ_TX_EMPTY = 1;
    localparam int IRQ_ERR      = 2;

    localparam logic [1:0] DATA_FLAG_RST = 2'b11;
    localparam logic [8:0] RX_THR_RST    = 9'd1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_POP,
        ST_LATCH,
        ST_ACK
    } state_t;

endpackage

// File: rtl/pp_soft_rst_gen.sv
// Active-low soft reset pulse generator with load/reload counter.
// Pulse starts the cycle after a trigger and lasts CYCLES cycles.
// A trigger while active reloads the counter; no backpressure.
module pp_soft_rst_gen #(
    parameter int CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_trig,
    output logic o_soft_rst
);

    logic [3:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_trig) begin
            r_cnt <= 4'(CYCLES);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign o_soft_rst = (r_cnt == '0);

endmodule

// File: rtl/pp_uart0_regif.sv
// Slave-bus register interface for the UART0 wrapper: config, FIFO strobes, irq.
// bus_ready at T+1 for ordinary accesses, T+3 for an RXDATA pop.
// Master holds the request until bus_ready; FIFO full/empty is never gated.
module pp_uart0_regif
    import pp_uart_regif_pkg::*;
#(
    parameter int BAUD_RST        = 434,
    parameter int SOFT_RST_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_cs,
    input  logic        bus_we,
    input  logic [3:0]  bus_addr,
    input  logic [15:0] bus_wdata,
    output logic [15:0] bus_rdata,
    output logic        bus_ready,
    output logic        irq,
    output logic        soft_rst,
    output logic        tx_fifo_wrreq,
    output logic [7:0]  tx_fifo_data,
    output logic        rx_fifo_rdreq,
    input  logic [7:0]  rx_fifo_q,
    input  logic [8:0]  tx_fifo_wrusedw,
    input  logic [8:0]  rx_fifo_rdusedw,
    input  logic        tx_fifo_wrfull,
    input  logic        tx_fifo_rdempty,
    input  logic        rx_fifo_wrfull,
    input  logic        rx_fifo_rdempty,
    input  logic        tx_error,
    input  logic        rx_error,
    output logic [1:0]  uart_data_flag,
    output logic        uart_stop_flag,
    output logic [1:0]  uart_check_flag,
    output logic [13:0] uart_baud_rate
);

    state_t      r_state, w_next;
    logic [1:0]  r_data_flag, r_check;
    logic        r_stop;
    logic [13:0] r_baud;
    logic [2:0]  r_irq_en;
    logic [8:0]  r_rx_thr;
    logic [15:0] r_rdata;
    logic        r_tx_wrreq, r_pop_ok, r_irq;
    logic [7:0]  r_tx_data;

    logic        w_acc, w_wr, w_rd, w_tx_push, w_srst_trig, w_soft_rst;
    logic [2:0]  w_src;
    logic [15:0] w_status, w_rmux;
    logic        w_unused;

    assign w_acc       = (r_state == ST_IDLE) && bus_cs;
    assign w_wr        = w_acc && bus_we;
    assign w_rd        = w_acc && !bus_we;
    assign w_tx_push   = w_wr && (bus_addr == ADDR_TXDATA) && w_soft_rst;
    assign w_srst_trig = w_wr && (bus_addr == ADDR_CTRL) && bus_wdata[CTRL_SRST_BIT];
    assign w_unused    = &{1'b0, bus_wdata[14]};

    pp_soft_rst_gen #(.CYCLES(SOFT_RST_CYCLES)) u_soft_rst_gen (
        .clk        (clk),
        .rst        (rst),
        .i_trig     (w_srst_trig),
        .o_soft_rst (w_soft_rst)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (bus_cs) w_next = (!bus_we && bus_addr == ADDR_RXDATA) ? ST_POP : ST_ACK;
            ST_POP:   w_next = ST_LATCH;
            ST_LATCH: w_next = ST_ACK;
            ST_ACK:   w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_status                 = '0;
        w_status[STS_TX_WRFULL]  = tx_fifo_wrfull;
        w_status[STS_TX_RDEMPTY] = tx_fifo_rdempty;
        w_status[STS_RX_WRFULL]  = rx_fifo_wrfull;
        w_status[STS_RX_RDEMPTY] = rx_fifo_rdempty;
        w_status[STS_TX_ERROR]   = tx_error;
        w_status[STS_RX_ERROR]   = rx_error;
        w_status[STS_IRQ]        = r_irq;
    end

    // RXDATA is not muxed here: its data is captured later, in LATCH.
    always_comb begin
        w_rmux = '0;
        case (bus_addr)
            ADDR_CTRL:   w_rmux = {11'd0, r_check, r_stop, r_data_flag};
            ADDR_BAUD:   w_rmux = {2'd0, r_baud};
            ADDR_STATUS: w_rmux = w_status;
            ADDR_TXLVL:  w_rmux = {7'd0, tx_fifo_wrusedw};
            ADDR_RXLVL:  w_rmux = {7'd0, rx_fifo_rdusedw};
            ADDR_IRQ_EN: w_rmux = {13'd0, r_irq_en};
            ADDR_RX_THR: w_rmux = {7'd0, r_rx_thr};
            default:     w_rmux = '0;
        endcase
    end

    assign w_src[IRQ_RX_LVL]   = (r_rx_thr != '0) && (rx_fifo_rdusedw >= r_rx_thr);
    assign w_src[IRQ_TX_EMPTY] = tx_fifo_rdempty;
    assign w_src[IRQ_ERR]      = tx_error | rx_error;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data_flag <= DATA_FLAG_RST;
            r_stop      <= 1'b0;
            r_check     <= 2'b00;
            r_baud      <= 14'(BAUD_RST);
            r_irq_en    <= '0;
            r_rx_thr    <= RX_THR_RST;
        end else if (w_wr) begin
            case (bus_addr)
                ADDR_CTRL: begin
                    r_data_flag <= bus_wdata[CTRL_DATA_LSB +: 2];
                    r_stop      <= bus_wdata[CTRL_STOP_BIT];
                    r_check     <= bus_wdata[CTRL_CHECK_LSB +: 2];
                end
                ADDR_BAUD:   r_baud   <= bus_wdata[13:0];
                ADDR_IRQ_EN: r_irq_en <= bus_wdata[2:0];
                ADDR_RX_THR: r_rx_thr <= bus_wdata[8:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata    <= '0;
            r_tx_wrreq <= 1'b0;
            r_tx_data  <= '0;
            r_pop_ok   <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_tx_wrreq <= w_tx_push;
            r_irq      <= |(r_irq_en & w_src);
            if (w_tx_push) r_tx_data <= bus_wdata[7:0];
            // Empty/suppressed pops still complete but must read as zero.
            if (r_state == ST_POP) r_pop_ok <= w_soft_rst && !rx_fifo_rdempty;
            if (w_rd) begin
                r_rdata <= w_rmux;
            end else if (w_wr) begin
                r_rdata <= '0;
            end else if (r_state == ST_LATCH) begin
                r_rdata <= r_pop_ok ? {8'h00, rx_fifo_q} : 16'h0000;
            end
        end
    end

    assign bus_rdata       = r_rdata;
    assign bus_ready       = (r_state == ST_ACK);
    assign irq             = r_irq;
    assign soft_rst        = w_soft_rst;
    assign tx_fifo_wrreq   = r_tx_wrreq;
    assign tx_fifo_data    = r_tx_data;
    assign rx_fifo_rdreq   = (r_state == ST_POP) && w_soft_rst;
    assign uart_data_flag  = r_data_flag;
    assign uart_stop_flag  = r_stop;
    assign uart_check_flag = r_check;
    assign uart_baud_rate  = r_baud;

endmodule
